pgm_ddram_rd_bridge: RTL

PGM_DDRAM_RD_BRIDGE -- requirements
Module: pgm_ddram_rd_bridge

---
 rtl/pgm_pkg.sv | 16 +
 rtl/pgm_ddram_rd_bridge_if.sv | 34 +++
 rtl/pgm_ddram_line.sv | 47 ++++
 rtl/pgm_ddram_rd_bridge.sv | 137 +++++++++++++
 4 files changed

// File: rtl/pgm_pkg.sv
// Shared types and Avalon width constants for the DDRAM read bridge.
package pgm_pkg;

  localparam int unsigned ADDR_W            = 29;
  localparam int unsigned DATA_W            = 64;
  localparam int unsigned BURSTCNT_W        = 8;
  localparam int unsigned BURST_LEN_DEFAULT = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StFill,
    StRespond
  } bridge_state_e;

endpackage

// File: rtl/pgm_ddram_rd_bridge_if.sv
// Client-side read port plus Avalon read master signals of the DDRAM read bridge.
interface pgm_ddram_rd_bridge_if;
  import pgm_pkg::*;

  logic                  ddram_rd;
  logic [ADDR_W-1:0]     ddram_addr;
  logic                  ddram_busy;
  logic [DATA_W-1:0]     ddram_dout;
  logic                  ddram_dout_ready;
  logic                  inval;

  logic                  DDRAM_BUSY;
  logic [ADDR_W-1:0]     DDRAM_ADDR;
  logic [BURSTCNT_W-1:0] DDRAM_BURSTCNT;
  logic                  DDRAM_RD;
  logic [DATA_W-1:0]     DDRAM_DOUT;
  logic                  DDRAM_DOUT_READY;
  logic                  DDRAM_WE;
  logic [DATA_W-1:0]     DDRAM_DIN;
  logic [7:0]            DDRAM_BE;

  modport slave (
    input  ddram_rd, ddram_addr, inval, DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    output ddram_busy, ddram_dout, ddram_dout_ready,
           DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE
  );

  modport master (
    output ddram_rd, ddram_addr, inval, DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
    input  ddram_busy, ddram_dout, ddram_dout_ready,
           DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE
  );

endinterface

// File: rtl/pgm_ddram_line.sv
// Single cache line: BURST_LEN words, tag and valid bit with a combinational hit compare.
module pgm_ddram_line
  import pgm_pkg::*;
#(
  parameter int unsigned BURST_LEN = BURST_LEN_DEFAULT,
  localparam int unsigned OFF_W    = $clog2(BURST_LEN),
  localparam int unsigned TAG_W    = ADDR_W - OFF_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [OFF_W-1:0]  widx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [OFF_W-1:0]  ridx_i,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              set_valid_i,
  input  logic [TAG_W-1:0]  set_tag_i,
  input  logic              inval_i,
  input  logic [TAG_W-1:0]  cmp_tag_i,
  output logic              hit_o
);

  logic [DATA_W-1:0] line_q [BURST_LEN];
  logic [TAG_W-1:0]  tag_q;
  logic              valid_q;

  always_ff @(posedge clk_i) begin
    if (we_i) line_q[widx_i] <= wdata_i;
  end

  // Invalidate wins over a fill completing in the same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else if (inval_i) begin
      valid_q <= 1'b0;
    end else if (set_valid_i) begin
      valid_q <= 1'b1;
      tag_q   <= set_tag_i;
    end
  end

  assign rdata_o = line_q[ridx_i];
  assign hit_o   = valid_q && (tag_q == cmp_tag_i);

endmodule

// File: rtl/pgm_ddram_rd_bridge.sv
// Client read port to Avalon burst-read bridge with an optional one-line cache.
// Define PGM_DDRAM_CACHE_EN to enable the line cache; otherwise every read is a single beat.
module pgm_ddram_rd_bridge
  import pgm_pkg::*;
#(
  parameter int unsigned BURST_LEN = BURST_LEN_DEFAULT
) (
  input logic                  clk,
  input logic                  reset,
  pgm_ddram_rd_bridge_if.slave bus
);

  localparam int unsigned OFF_W = $clog2(BURST_LEN);
`ifdef PGM_DDRAM_CACHE_EN
  localparam int unsigned Beats = BURST_LEN;
`else
  localparam int unsigned Beats = 1;
`endif
  localparam logic [OFF_W-1:0]      LastBeat = OFF_W'(Beats - 1);
  localparam logic [BURSTCNT_W-1:0] BurstCnt = BURSTCNT_W'(Beats);

  bridge_state_e         state_q;
  logic [ADDR_W-1:0]     req_addr_q;
  logic [OFF_W-1:0]      beat_cnt_q;
  logic                  rd_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [BURSTCNT_W-1:0] burstcnt_q;
  logic [DATA_W-1:0]     last_q;
  logic                  kill_q;

  logic                  fill_we;
  logic                  hit;
  logic [ADDR_W-1:0]     miss_addr;
  logic [DATA_W-1:0]     line_rdata;

  assign fill_we = (state_q == StFill) && bus.DDRAM_DOUT_READY;

`ifdef PGM_DDRAM_CACHE_EN
  logic line_hit;
  logic set_valid;

  // An inval seen anywhere during the miss keeps the refilled line invalid.
  assign set_valid = fill_we && (beat_cnt_q == LastBeat) && !kill_q && !bus.inval;

  pgm_ddram_line #(
    .BURST_LEN (BURST_LEN)
  ) u_line (
    .clk_i       (clk),
    .reset_i     (reset),
    .we_i        (fill_we),
    .widx_i      (beat_cnt_q),
    .wdata_i     (bus.DDRAM_DOUT),
    .ridx_i      (req_addr_q[OFF_W-1:0]),
    .rdata_o     (line_rdata),
    .set_valid_i (set_valid),
    .set_tag_i   (req_addr_q[ADDR_W-1:OFF_W]),
    .inval_i     (bus.inval),
    .cmp_tag_i   (bus.ddram_addr[ADDR_W-1:OFF_W]),
    .hit_o       (line_hit)
  );

  assign hit       = line_hit && !bus.inval;
  assign miss_addr = {bus.ddram_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
`else
  logic [DATA_W-1:0] word_q;
  logic              unused_nocache;

  always_ff @(posedge clk) begin
    if (fill_we) word_q <= bus.DDRAM_DOUT;
  end

  assign line_rdata     = word_q;
  assign hit            = 1'b0;
  assign miss_addr      = bus.ddram_addr;
  assign unused_nocache = ^{bus.inval, kill_q, req_addr_q};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      req_addr_q <= '0;
      beat_cnt_q <= '0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      burstcnt_q <= BURSTCNT_W'(BURST_LEN);
      last_q     <= '0;
      kill_q     <= 1'b0;
    end else begin
      if ((state_q != StIdle) && bus.inval) kill_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (bus.ddram_rd) begin
            req_addr_q <= bus.ddram_addr;
            kill_q     <= 1'b0;
            if (hit) begin
              state_q <= StRespond;
            end else begin
              state_q    <= StIssue;
              rd_q       <= 1'b1;
              addr_q     <= miss_addr;
              burstcnt_q <= BurstCnt;
            end
          end
        end
        StIssue: begin
          if (!bus.DDRAM_BUSY) begin
            rd_q       <= 1'b0;
            beat_cnt_q <= '0;
            state_q    <= StFill;
          end
        end
        StFill: begin
          if (bus.DDRAM_DOUT_READY) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q == LastBeat) state_q <= StRespond;
          end
        end
        StRespond: begin
          last_q  <= line_rdata;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ddram_busy       = (state_q != StIdle);
  assign bus.ddram_dout_ready = (state_q == StRespond);
  assign bus.ddram_dout       = (state_q == StRespond) ? line_rdata : last_q;
  assign bus.DDRAM_RD         = rd_q;
  assign bus.DDRAM_ADDR       = addr_q;
  assign bus.DDRAM_BURSTCNT   = burstcnt_q;
  assign bus.DDRAM_WE         = 1'b0;
  assign bus.DDRAM_DIN        = '0;
  assign bus.DDRAM_BE         = 8'hFF;

endmodule
